// File: rtl/bch_dec_frame_sched_if.sv
// Stream interfaces around the BCH decoder input scheduler: the upstream
// bit stream (valid/ready) and the framed decoder-side stream.

interface bch_bit_if;
    logic ival;
    logic idat;
    logic ordy;

    modport master (output ival, output idat, input ordy);
    modport slave  (input ival, input idat, output ordy);
endinterface

interface bch_frame_if;
    logic osop;
    logic oval;
    logic oeop;
    logic odat;
    logic idone;

    modport master (output osop, output oval, output oeop, output odat, input idone);
    modport slave  (input osop, input oval, input oeop, input odat, output idone);
endinterface

// File: rtl/bch_dec_frame_sched.sv
// Frames a valid/ready bit stream into sop/val/eop codewords for the BCH
// decoder and withholds ready so the decoder input buffer never overruns.

module bch_dec_frame_sched #(
    parameter int m          = 4,
    parameter int n          = 15,
    parameter int pFRAME_MAX = 4
) (
    input  logic          iclk,
    input  logic          ireset,
    input  logic          iclkena,
    input  logic [m-1:0]  ilen,
    bch_bit_if.slave      i_bit,
    bch_frame_if.master   o_frm,
    output logic [2:0]    oinflight,
    output logic          obusy,
    output logic          oerr
);

    localparam logic [m-1:0] LP_N   = m'(n);
    localparam logic [2:0]   LP_MAX = 3'(pFRAME_MAX);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t       r_state;
    logic [m-1:0] r_bit_cnt;
    logic [m-1:0] r_len_q;
    logic [2:0]   r_inflight;
    logic         r_sop;
    logic         r_val;
    logic         r_eop;
    logic         r_dat;
    logic         r_err;

    state_t       w_state_nxt;
    logic [m-1:0] w_cnt_nxt;
    logic [m-1:0] w_len_nxt;
    logic [m-1:0] w_len_sel;
    logic [2:0]   w_inflight_nxt;
    logic         w_err_nxt;
    logic         w_rdy;
    logic         w_xfer;
    logic         w_start;
    logic         w_sop;
    logic         w_eop;

    // Ready in IDLE also requires decoder buffer credit; RUN never stalls.
    assign w_len_sel = (ilen == '0 || ilen > LP_N) ? LP_N : ilen;
    assign w_rdy     = iclkena & ((r_state == ST_RUN) | (r_inflight < LP_MAX));
    assign w_xfer    = i_bit.ival & w_rdy;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_len_nxt   = r_len_q;
        w_start     = 1'b0;
        w_sop       = 1'b0;
        w_eop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_start   = 1'b1;
                    w_sop     = 1'b1;
                    w_len_nxt = w_len_sel;
                    if (w_len_sel == m'(1)) begin
                        w_eop     = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt   = m'(1);
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_xfer) begin
                    if (r_bit_cnt == r_len_q - m'(1)) begin
                        w_eop       = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_bit_cnt + m'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Credit is taken at frame start; a completion with nothing in flight is an error.
    always_comb begin
        w_inflight_nxt = r_inflight;
        w_err_nxt      = r_err;
        case ({w_start, o_frm.idone})
            2'b10: if (r_inflight != LP_MAX) w_inflight_nxt = r_inflight + 3'd1;
            2'b01: begin
                if (r_inflight == 3'd0) w_err_nxt      = 1'b1;
                else                    w_inflight_nxt = r_inflight - 3'd1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_len_q    <= LP_N;
            r_inflight <= '0;
            r_sop      <= 1'b0;
            r_val      <= 1'b0;
            r_eop      <= 1'b0;
            r_dat      <= 1'b0;
            r_err      <= 1'b0;
        end else if (iclkena) begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_cnt_nxt;
            r_len_q    <= w_len_nxt;
            r_inflight <= w_inflight_nxt;
            r_err      <= w_err_nxt;
            r_sop      <= w_sop;
            r_val      <= w_xfer;
            r_eop      <= w_eop;
            if (w_xfer) begin
                r_dat <= i_bit.idat;
            end
        end
    end

    assign i_bit.ordy = w_rdy;
    assign o_frm.osop = r_sop;
    assign o_frm.oval = r_val;
    assign o_frm.oeop = r_eop;
    assign o_frm.odat = r_dat;
    assign oinflight  = r_inflight;
    assign obusy      = (r_state == ST_RUN);
    assign oerr       = r_err;

endmodule

// File: tb/tb_bch_dec_frame_sched.sv
// Self-checking bench for bch_dec_frame_sched: directed scenarios then a
// random phase, all compared against a frame-level reference model.

module tb_bch_dec_frame_sched;

    localparam int M    = 4;
    localparam int N    = 15;
    localparam int FMAX = 4;

    logic         iclk = 1'b0;
    logic         ireset;
    logic         iclkena;
    logic [M-1:0] ilen;
    logic [2:0]   oinflight;
    logic         obusy;
    logic         oerr;

    bch_bit_if   u_bit ();
    bch_frame_if u_frm ();

    bch_dec_frame_sched #(
        .m          (M),
        .n          (N),
        .pFRAME_MAX (FMAX)
    ) u_dut (
        .iclk      (iclk),
        .ireset    (ireset),
        .iclkena   (iclkena),
        .ilen      (ilen),
        .i_bit     (u_bit.slave),
        .o_frm     (u_frm.master),
        .oinflight (oinflight),
        .obusy     (obusy),
        .oerr      (oerr)
    );

    always #5 iclk = ~iclk;

    int tests = 0;
    int fails = 0;

    // Reference model: frame membership, bits still owed, frames outstanding.
    bit m_in_frame;
    int m_left;
    int m_inflight;
    bit m_err;
    bit e_sop, e_val, e_eop, e_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("osop", 32'(u_frm.osop), 32'(e_sop));
        chk("oval", 32'(u_frm.oval), 32'(e_val));
        chk("oeop", 32'(u_frm.oeop), 32'(e_eop));
        chk("odat", 32'(u_frm.odat), 32'(e_dat));
        chk("oinflight", 32'(oinflight), 32'(m_inflight));
        chk("obusy", 32'(obusy), 32'(m_in_frame));
        chk("oerr", 32'(oerr), 32'(m_err));
    endtask

    task automatic do_reset();
        ireset        = 1'b1;
        iclkena       = 1'b1;
        u_bit.ival    = 1'b0;
        u_bit.idat    = 1'b0;
        u_frm.idone   = 1'b0;
        ilen          = '0;
        @(posedge iclk);
        #1;
        m_in_frame = 0; m_left = 0; m_inflight = 0; m_err = 0;
        e_sop = 0; e_val = 0; e_eop = 0; e_dat = 0;
        check_outputs();
        ireset = 1'b0;
    endtask

    // One clock: drive inputs, check ready, advance, update model, check outputs.
    task automatic step(input bit en, input bit v, input bit d, input bit dn, input int len);
        bit exp_rdy, xfer, start;
        int flen;
        ireset      = 1'b0;
        iclkena     = en;
        u_bit.ival  = v;
        u_bit.idat  = d;
        u_frm.idone = dn;
        ilen        = M'(len);
        #1;
        exp_rdy = en && (m_in_frame || m_inflight < FMAX);
        chk("ordy", 32'(u_bit.ordy), 32'(exp_rdy));
        xfer  = v && exp_rdy;
        start = xfer && !m_in_frame;
        @(posedge iclk);
        #1;
        if (en) begin
            e_val = xfer;
            e_sop = start;
            e_eop = 0;
            if (xfer) e_dat = d;
            if (start) begin
                flen   = (len == 0 || len > N) ? N : len;
                m_left = flen - 1;
                if (m_left == 0) e_eop = 1;
                else             m_in_frame = 1;
            end else if (xfer) begin
                m_left--;
                if (m_left == 0) begin
                    e_eop      = 1;
                    m_in_frame = 0;
                end
            end
            if (start && !dn) begin
                if (m_inflight < FMAX) m_inflight++;
            end else if (dn && !start) begin
                if (m_inflight == 0) m_err = 1;
                else                 m_inflight--;
            end
        end
        check_outputs();
    endtask

    task automatic send_frame(input int len);
        int k;
        k = 0;
        step(1, 1, 1'($urandom), 0, len);
        while (m_in_frame && k < 40) begin
            step(1, 1, 1'($urandom), 0, len);
            k++;
        end
    endtask

    initial begin
        do_reset();

        // Default length (ilen=0) with continuous valid.
        send_frame(0);
        chk("t1_eop", 32'(u_frm.oeop), 32'd1);
        chk("t1_inflight", 32'(oinflight), 32'd1);
        step(1, 0, 0, 0, 0);

        // Length 7 with alternating gaps; ilen changes mid-frame are ignored.
        for (int i = 0; i < 14; i++) begin
            step(1, (i % 2) == 0, 1'($urandom), 0, (i < 3) ? 7 : 3);
            if (i == 6) chk("t2_busy_mid", 32'(obusy), 32'd1);
        end
        chk("t2_inflight", 32'(oinflight), 32'd2);

        // Fill all credits, stall with valid held, release with one idone.
        send_frame(15);
        send_frame(0);
        chk("t3_inflight_full", 32'(oinflight), 32'd4);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0);
        chk("t3_inflight_rel", 32'(oinflight), 32'd3);
        send_frame(0);
        chk("t3_refill", 32'(oinflight), 32'd4);

        // Coincident start and idone at two in flight.
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 1, 1, 1, 5);
        chk("t4_net_zero", 32'(oinflight), 32'd2);
        for (int i = 0; i < 12 && m_in_frame; i++) step(1, 1'($urandom), 1'($urandom), 0, 5);

        // Single-bit frame: sop and eop together, no RUN.
        step(1, 1, 1, 0, 1);
        chk("len1_sop", 32'(u_frm.osop), 32'd1);
        chk("len1_eop", 32'(u_frm.oeop), 32'd1);
        step(1, 1, 0, 0, 1);

        // Drain credits, then an extra idone raises the sticky error.
        for (int i = 0; i < 8 && m_inflight > 0; i++) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        chk("t5_err", 32'(oerr), 32'd1);
        chk("t5_inflight0", 32'(oinflight), 32'd0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        do_reset();

        // Clock-enable stall mid-frame, then completion.
        step(1, 1, 1, 0, 5);
        step(1, 1, 0, 0, 5);
        for (int i = 0; i < 3; i++) step(0, 1, 1'($urandom), 0, 5);
        for (int i = 0; i < 8 && m_in_frame; i++) step(1, 1, 1'($urandom), 0, 5);

        // Reset mid-frame discards the partial frame.
        step(1, 1, 1, 0, 9);
        step(1, 1, 1, 0, 9);
        do_reset();
        step(1, 0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, 1'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 15));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
